// File: rtl/systolic_operand_reader_pkg.sv
// Shared widths and bank address arithmetic for the systolic operand reader.
`timescale 1ns/1ps
package systolic_operand_reader_pkg;

  function automatic int clog2_min1(input int v);
    int c;
    c = $clog2(v);
    return (c < 1) ? 1 : c;
  endfunction

  function automatic int aw_of(input int m, input int n);
    return clog2_min1(m * m / n);
  endfunction

  function automatic int cw_of(input int m);
    return clog2_min1(m);
  endfunction

  function automatic int tw_of(input int m, input int n);
    return clog2_min1(m / n);
  endfunction

  // A banks hold M/N whole rows, row-major.
  function automatic int unsigned addr_a(input int unsigned row, input int unsigned col,
                                         input int unsigned m);
    return row * m + col;
  endfunction

  // B banks hold M/N whole columns, k-major.
  function automatic int unsigned addr_b(input int unsigned row, input int unsigned col,
                                         input int unsigned m, input int unsigned n);
    return row * (m / n) + col;
  endfunction

endpackage

// File: rtl/systolic_operand_reader_pipe.sv
// Plain shift register with asynchronous active-low clear; depth 0 is a wire.
`timescale 1ns/1ps
module systolic_operand_reader_pipe #(
  parameter int D_W   = 8,
  parameter int pipes = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [D_W-1:0] d,
  output logic [D_W-1:0] q
);

  if (pipes == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign q = d;
  end else begin : g_reg
    logic [D_W-1:0] stage [pipes];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < pipes; i++) stage[i] <= '0;
      end else begin
        stage[0] <= d;
        for (int i = 1; i < pipes; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[pipes-1];
  end

endmodule

// File: rtl/systolic_operand_reader.sv
// Tile-schedule counters and diagonally skewed per-bank read address/enable lanes.
`timescale 1ns/1ps
module systolic_operand_reader
  import systolic_operand_reader_pkg::*;
#(
  parameter int D_W = 8,
  parameter int N   = 2,
  parameter int M   = 4,
  localparam int AW = aw_of(M, N),
  localparam int CW = cw_of(M),
  localparam int TW = tw_of(M, N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_en,
  output logic [TW-1:0] row_m0,
  output logic [CW-1:0] column_m0,
  output logic [CW-1:0] row_m1,
  output logic [TW-1:0] column_m1,
  output logic [AW-1:0] rd_addr_m0 [N],
  output logic [N-1:0]  rd_en_m0,
  output logic [AW-1:0] rd_addr_m1 [N],
  output logic [N-1:0]  rd_en_m1
);

  // Operand width only matters to the array; kept so both share one parameter set.
  localparam int unused_d_w = D_W;

  logic [TW-1:0] row_a, pass_a, col_b;
  logic [CW-1:0] col_a, row_b;
  logic          col_a_last, pass_a_last, row_a_last, row_b_last, col_b_last;
  logic          lane0_en;
  logic [AW-1:0] addr0_a, addr0_b;
  logic [AW:0]   lane_a [N];
  logic [AW:0]   lane_b [N];

  assign col_a_last  = (col_a  == CW'(M - 1));
  assign pass_a_last = (pass_a == TW'(M / N - 1));
  assign row_a_last  = (row_a  == TW'(M / N - 1));
  assign row_b_last  = (row_b  == CW'(M - 1));
  assign col_b_last  = (col_b  == TW'(M / N - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_a  <= '0;
      pass_a <= '0;
      col_a  <= '0;
      row_b  <= '0;
      col_b  <= '0;
    end else if (rd_en) begin
      col_a <= col_a_last ? '0 : col_a + 1'b1;
      if (col_a_last) begin
        pass_a <= pass_a_last ? '0 : pass_a + 1'b1;
        if (pass_a_last) row_a <= row_a_last ? '0 : row_a + 1'b1;
      end
      row_b <= row_b_last ? '0 : row_b + 1'b1;
      if (row_b_last) col_b <= col_b_last ? '0 : col_b + 1'b1;
    end
  end

  assign row_m0    = row_a;
  assign column_m0 = col_a;
  assign row_m1    = row_b;
  assign column_m1 = col_b;

  // Gated by reset so lane 0 also reads zero while reset is held.
  assign lane0_en = rd_en & rst;
  assign addr0_a  = AW'(addr_a(32'(row_a), 32'(col_a), M));
  assign addr0_b  = AW'(addr_b(32'(row_b), 32'(col_b), M, N));

  for (genvar x = 0; x < N; x++) begin : g_lane
    systolic_operand_reader_pipe #(.D_W(AW + 1), .pipes(x)) u_pipe_a (
      .clk   (clk),
      .rst_n (rst),
      .d     ({lane0_en, addr0_a}),
      .q     (lane_a[x])
    );
    systolic_operand_reader_pipe #(.D_W(AW + 1), .pipes(x)) u_pipe_b (
      .clk   (clk),
      .rst_n (rst),
      .d     ({lane0_en, addr0_b}),
      .q     (lane_b[x])
    );
    assign rd_en_m0[x]   = lane_a[x][AW];
    assign rd_addr_m0[x] = lane_a[x][AW-1:0];
    assign rd_en_m1[x]   = lane_b[x][AW];
    assign rd_addr_m1[x] = lane_b[x][AW-1:0];
  end

endmodule

// File: tb/tb_systolic_operand_reader.sv
// Directed bench for the operand reader at N=2, M=4 with a lane-1 expectation queue.
`timescale 1ns/1ps
module tb_systolic_operand_reader;
  localparam int N  = 2;
  localparam int M  = 4;
  localparam int AW = 3;
  localparam int CW = 2;
  localparam int TW = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rd_en = 1'b0;
  logic [TW-1:0] row_m0, column_m1;
  logic [CW-1:0] column_m0, row_m1;
  logic [AW-1:0] rd_addr_m0 [N];
  logic [AW-1:0] rd_addr_m1 [N];
  logic [N-1:0]  rd_en_m0, rd_en_m1;

  systolic_operand_reader #(.D_W(8), .N(N), .M(M)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .row_m0     (row_m0),
    .column_m0  (column_m0),
    .row_m1     (row_m1),
    .column_m1  (column_m1),
    .rd_addr_m0 (rd_addr_m0),
    .rd_en_m0   (rd_en_m0),
    .rd_addr_m1 (rd_addr_m1),
    .rd_en_m1   (rd_en_m1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int k     = 0;
  logic [2*AW:0] exp_q[$];
  int a_seq [16] = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5, 6, 7, 4, 5, 6, 7};
  int b_seq [16] = '{0, 2, 4, 6, 1, 3, 5, 7, 0, 2, 4, 6, 1, 3, 5, 7};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_row_m0"}, 32'(row_m0), 0);
    chk({tag, "_col_m0"}, 32'(column_m0), 0);
    chk({tag, "_row_m1"}, 32'(row_m1), 0);
    chk({tag, "_col_m1"}, 32'(column_m1), 0);
    chk({tag, "_en_m0"}, 32'(rd_en_m0), 0);
    chk({tag, "_en_m1"}, 32'(rd_en_m1), 0);
    for (int x = 0; x < N; x++) begin
      chk({tag, "_addr_m0"}, 32'(rd_addr_m0[x]), 0);
      chk({tag, "_addr_m1"}, 32'(rd_addr_m1[x]), 0);
    end
  endtask

  // One clock: drive rd_en after the falling edge, then check against the model.
  task automatic cycle(input logic en);
    logic [2*AW:0] e1;
    logic [AW-1:0] ea, eb;
    @(negedge clk);
    rd_en = en;
    #1;
    ea = AW'(a_seq[k % 16]);
    eb = AW'(b_seq[k % 16]);
    chk("cnt_col_m0", 32'(column_m0), 32'(k % 4));
    chk("cnt_row_m0", 32'(row_m0), 32'((k / 8) % 2));
    chk("cnt_row_m1", 32'(row_m1), 32'(k % 4));
    chk("cnt_col_m1", 32'(column_m1), 32'((k / 4) % 2));
    chk("lane0_en_m0", 32'(rd_en_m0[0]), 32'(en));
    chk("lane0_en_m1", 32'(rd_en_m1[0]), 32'(en));
    if (en) begin
      chk("lane0_addr_m0", 32'(rd_addr_m0[0]), 32'(ea));
      chk("lane0_addr_m1", 32'(rd_addr_m1[0]), 32'(eb));
    end
    e1 = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk("lane1_en_m0", 32'(rd_en_m0[1]), 32'(e1[2*AW]));
    chk("lane1_en_m1", 32'(rd_en_m1[1]), 32'(e1[2*AW]));
    if (e1[2*AW]) begin
      chk("lane1_addr_m0", 32'(rd_addr_m0[1]), 32'(e1[2*AW-1:AW]));
      chk("lane1_addr_m1", 32'(rd_addr_m1[1]), 32'(e1[AW-1:0]));
    end
    exp_q.push_back({en, ea, eb});
    if (en) k++;
  endtask

  task automatic model_reset();
    exp_q.delete();
    k = 0;
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero(tag);
    model_reset();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rd_en = 1'b0;
    rst   = 1'b1;
  endtask

  initial begin
    // Reset held with rd_en high: everything reads zero.
    rst   = 1'b0;
    rd_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset_hold");
    model_reset();
    release_reset();

    // Continuous stream across a full product wrap and beyond.
    repeat (20) cycle(1'b1);

    // Asynchronous clear mid-cycle with lanes active.
    async_reset("async_clear");
    release_reset();

    // Stall after m0 address 5 (10th enabled cycle), then resume at 6.
    repeat (10) cycle(1'b1);
    repeat (3) cycle(1'b0);
    repeat (6) cycle(1'b1);

    // Reset at cycle 9, then idle before restarting from zero.
    async_reset("midrun_clear");
    release_reset();
    repeat (9) cycle(1'b1);
    async_reset("cycle9_clear");
    release_reset();
    repeat (2) cycle(1'b0);
    repeat (8) cycle(1'b1);

    // Random enable pattern.
    for (int i = 0; i < 40; i++) cycle(1'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_operand_reader.md
# systolic_operand_reader

Read-side address generator for the two operand BRAM bank sets of an N×N systolic matrix multiplier computing C = A·B with M×M matrices. Each of the two generators, m0 for A and m1 for B, drives N banks. Each generator steps through the tile schedule and emits per-bank read addresses and read enables. Lane x is skewed by x cycles so that operands enter the array diagonally.

## Interface
- D_W, default 8: operand data width. Carried for consistency with the array; not used for any address width.
- N, default 2: array dimension and number of banks per operand. N must divide M.
- M, default 4: matrix dimension. Each bank holds M*M/N words.
- AW: localparam, max(1, clog2(M*M/N)), bank address width.
- CW: localparam, max(1, clog2(M)).
- TW: localparam, max(1, clog2(M/N)).

Ports:
- clk, in, 1: rising-edge clock.
- rst, in, 1: asynchronous, active-low reset.
- rd_en, in, 1: advance enable for the schedule.
- row_m0, out, TW: A row-tile index.
- column_m0, out, CW: A column, which is the k index.
- row_m1, out, CW: B row, which is the k index.
- column_m1, out, TW: B column-tile index.
- rd_addr_m0[N], out, AW each: A bank read addresses.
- rd_en_m0[N], out, N bits: A bank read enables.
- rd_addr_m1[N], out, AW each: B bank read addresses.
- rd_en_m1[N], out, N bits: B bank read enables.

## Operation
- Bank layout:
  - A bank x holds A rows x*(M/N) through x*(M/N)+M/N-1, stored row-major. Address = row_m0*M + column_m0.
  - B bank x holds B columns x*(M/N) through x*(M/N)+M/N-1. Address = row_m1*(M/N) + column_m1.
- Counters advance only in a cycle where rd_en=1. They hold while rd_en=0.
- m0 schedule:
  - column_m0 increments each cycle and wraps M-1→0.
  - A hidden pass counter (0..M/N-1) increments on each column_m0 wrap.
  - When the pass counter wraps, row_m0 increments, wrapping M/N-1→0.
- m1 schedule:
  - row_m1 increments each cycle and wraps M-1→0.
  - On each row_m1 wrap, column_m1 increments, wrapping M/N-1→0.
- One full product takes (M/N)²·M enabled cycles. The schedule then restarts at all-zero with no gap.
- Lane 0 address is computed combinationally from the current counter values. Lane 0 enable equals rd_en in the same cycle.
- Lane x (x≥1) carries exactly the lane-0 {enable, address} pair, delayed by x clock cycles through a shift register.
- While rd_en=0, zeros enter the enable pipelines. Addresses still shift through the pipelines but are don't-care whenever the matching enable is 0.
- Address arithmetic is unsigned. The product row·M + column never exceeds M*M/N-1, so no truncation occurs.

## Timing
- Reset asserted (rst=0) clears asynchronously: all counters, all pipeline stages, all addresses and all enables go to 0.
- Reset release: the first advance occurs on the first rising edge with rst=1 and rd_en=1.
- Latency from counter state to lane-x output is x cycles. The last lane lags lane 0 by N-1 cycles.
- rd_en deasserted: counters freeze on the same edge, and rd_en_*[x] goes low x cycles later.
- rd_en reasserted: the schedule resumes from the frozen counter values with no skipped or repeated addresses.
- Reset mid-operation clears all in-flight pipeline contents immediately. After release the schedule restarts from zero.
- A pass wrap and a tile wrap that fall on the same edge are applied together. Counters never stall at a boundary.

## Structure
- Shared package holds the AW, CW and TW width functions (max(1, clog2)) and the address-computation functions.
- One sub-module is natural: pipe, parameterised by width D_W and depth pipes.
  - It is a plain shift register with asynchronous active-low clear.
  - Depth 0 is a pass-through wire.
  - Instantiate it per lane for {enable, address}.
- Expected size is about 150–250 lines.

## Test plan
All scenarios use N=2, M=4, so AW=3 and bank size is 8.

- Reset: hold rst=0 with rd_en=1 → every output reads 0. Drop rst asynchronously mid-cycle → outputs clear without a clock edge.
- A stream with rd_en=1 continuously:
  - rd_addr_m0[0] = 0,1,2,3,0,1,2,3,4,5,6,7,4,5,6,7, then repeats.
  - rd_addr_m0[1] is the same sequence one cycle later.
  - rd_en_m0[1] first rises one cycle after rd_en_m0[0].
- B stream with rd_en=1 continuously: rd_addr_m1[0] = 0,2,4,6,1,3,5,7,0,2,4,6,1,3,5,7. Lane 1 lags lane 0 by 1 cycle.
- Wrap: after exactly 16 enabled cycles, all four counters return to 0 and lane-0 addresses restart at 0.
- Stall: drop rd_en for 3 cycles after the m0 address 5 is issued → lane-0 enable is low for 3 cycles and lane-1 enable is low 1 cycle later. The next m0 address issued is 6.
- Reset mid-run at cycle 9, then release → the sequence restarts at address 0 and both lanes' enables are 0 until rd_en is reasserted.
